gate_bist_ctrl: RTL

//  Self-test sequencer for a 2^N-row combinational logic gate (xnor/and/or/...).
//  On start it drives every input vector onto the gate-under-test (GUT), waits a

---
 rtl/gate_bist_pkg.sv | 23 ++
 rtl/bist_settle_timer.sv | 32 +++
 rtl/gate_bist_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate BIST sequencer.
// Truth-table constants use bit i = expected output for input vector i (MSB = first input).
package gate_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } bist_state_e;

    // Settle counter width covers SETTLE up to 15.
    localparam int unsigned SETTLE_W = 4;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage

// File: rtl/bist_settle_timer.sv
// Loadable down-counter that times the settle window between driving a vector
// and sampling the gate output.
module bist_settle_timer
    import gate_bist_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_dec,
    output logic o_expire
);

    localparam logic [SETTLE_W-1:0] LOAD_VAL = SETTLE_W'(SETTLE);

    logic [SETTLE_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Expires on the last settle cycle so WAIT lasts exactly SETTLE cycles.
    assign o_expire = (r_cnt <= SETTLE_W'(1));

endmodule

// File: rtl/gate_bist_ctrl.sv
// Self-test sequencer: walks every input vector of a small combinational gate,
// compares its output to a latched truth table and reports count/first failure.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [2**N_IN-1:0]   i_truth_tbl,
    output logic [N_IN-1:0]      o_gut_in,
    input  logic                 i_gut_out,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic [N_IN:0]        o_err_cnt,
    output logic                 o_fail_vld,
    output logic [N_IN-1:0]      o_fail_vec
);

    localparam logic [N_IN-1:0] LAST_VEC = '1;
    localparam logic [N_IN:0]   ERR_MAX  = {1'b1, {N_IN{1'b0}}};

    bist_state_e         r_state;
    logic [N_IN-1:0]     r_vec;
    logic [2**N_IN-1:0]  r_tt_q;
    logic [N_IN-1:0]     r_gut_in;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [N_IN:0]       r_err_cnt;
    logic                r_fail_vld;
    logic [N_IN-1:0]     r_fail_vec;

    logic                w_expire;
    logic                w_mismatch;
    logic [N_IN:0]       w_err_nxt;

    bist_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (r_state == APPLY),
        .i_dec    (r_state == WAIT),
        .o_expire (w_expire)
    );

    assign w_mismatch = (i_gut_out != r_tt_q[r_vec]);
    assign w_err_nxt  = (w_mismatch && (r_err_cnt != ERR_MAX)) ? r_err_cnt + 1'b1 : r_err_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_vec      <= '0;
            r_tt_q     <= '0;
            r_gut_in   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= '0;
            r_fail_vld <= 1'b0;
            r_fail_vec <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_abort && (r_state != IDLE)) begin
                // Partial results and the last driven vector are kept for debug.
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_pass  <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (i_start && !i_abort) begin
                            r_tt_q     <= i_truth_tbl;
                            r_vec      <= '0;
                            r_err_cnt  <= '0;
                            r_pass     <= 1'b0;
                            r_fail_vld <= 1'b0;
                            r_fail_vec <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= APPLY;
                        end
                    end
                    APPLY: begin
                        r_gut_in <= r_vec;
                        if (SETTLE == 0) r_state <= CHECK;
                        else             r_state <= WAIT;
                    end
                    WAIT: begin
                        if (w_expire) r_state <= CHECK;
                    end
                    CHECK: begin
                        r_err_cnt <= w_err_nxt;
                        if (w_mismatch && !r_fail_vld) begin
                            r_fail_vld <= 1'b1;
                            r_fail_vec <= r_vec;
                        end
                        if (r_vec == LAST_VEC) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_nxt == '0);
                            r_state <= DONE;
                        end else begin
                            r_vec   <= r_vec + 1'b1;
                            r_state <= APPLY;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_gut_in   = r_gut_in;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_pass     = r_pass;
    assign o_err_cnt  = r_err_cnt;
    assign o_fail_vld = r_fail_vld;
    assign o_fail_vec = r_fail_vec;

endmodule
